fmlarb2: RTL

FMLARB2 -- requirements
Module: fmlarb2

---
 rtl/fmlarb2_pkg.sv | 30 +++
 rtl/fmlarb2_rr.sv | 36 +++
 rtl/fmlarb2.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fmlarb2_pkg.sv
// fmlarb2_pkg
//
// Purpose: definitions shared by the two-master FML arbiter and its
// grant-decision helper.
//   state_t        arbiter FSM states
//   FML_BEATS      beats per FML burst
//   FML_DW         FML data width in bits
//   DATA_CNT_INIT  starting value of the post-ack beat counter
//
// Optional feature macro used by the files that import this package:
//   FMLARB2_FIXED_PRIO_EN  fixed priority (master 0 wins ties) instead of
//                          round-robin.

package fmlarb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam int FML_BEATS = 4;
    localparam int FML_DW    = 64;

    // Beat 0 happens in the ack cycle itself, so the DATA state only has to
    // cover the remaining beats.
    localparam logic [1:0] DATA_CNT_INIT = 2'(FML_BEATS - 1);

endpackage

// File: rtl/fmlarb2_rr.sv
// fmlarb2_rr
//
// Purpose: grant decision for two FML requesters.  A single requester always
// wins.  When both request, the master that was not served last wins
// (round-robin).  With FMLARB2_FIXED_PRIO_EN defined, master 0 wins every tie
// and the last-served input does not exist.
//
// Ports:
//   req0_i   master 0 request
//   req1_i   master 1 request
//   last1_i  1 = master 1 was served last (round-robin build only)
//   gnt1_o   1 = grant master 1, 0 = grant master 0 (meaningful only when a
//            request is present)
//
// Macro: FMLARB2_FIXED_PRIO_EN

module fmlarb2_rr (
    input  logic req0_i,
    input  logic req1_i,
`ifndef FMLARB2_FIXED_PRIO_EN
    input  logic last1_i,
`endif
    output logic gnt1_o
);

    // Master 1 wins when it is the only requester; on a tie it wins only
    // when master 0 was the one served most recently.
    always_comb begin
`ifdef FMLARB2_FIXED_PRIO_EN
        gnt1_o = req1_i & ~req0_i;
`else
        gnt1_o = req1_i & (~req0_i | ~last1_i);
`endif
    end

endmodule

// File: rtl/fmlarb2.sv
// fmlarb2
//
// Purpose: arbitrates two FML masters onto a single FML slave.  A burst is
// four 64-bit beats: beat 0 in the s_ack cycle, beats 1-3 in the following
// three cycles (the DATA state).  Read data is broadcast to both masters;
// only the owner's ack qualifies it.
//
// Ports:
//   sys_clk, sys_rst         clock, synchronous active-high reset
//   m0_adr/stb/we/sel/do     master 0 request, address, write strobe/data
//   m0_ack, m0_di            master 0 acknowledge, read data
//   m1_*                     master 1, same as master 0
//   s_adr/stb/we/sel/do      slave request, address, write strobe/data
//   s_ack, s_di              slave acknowledge, read data
//
// Parameter: fml_depth  FML address width
// Macro:     FMLARB2_FIXED_PRIO_EN  master 0 always wins ties

module fmlarb2
    import fmlarb2_pkg::*;
#(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,

    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    output logic                 m0_ack,
    input  logic [7:0]           m0_sel,
    input  logic [FML_DW-1:0]    m0_do,
    output logic [FML_DW-1:0]    m0_di,

    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    output logic                 m1_ack,
    input  logic [7:0]           m1_sel,
    input  logic [FML_DW-1:0]    m1_do,
    output logic [FML_DW-1:0]    m1_di,

    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    input  logic                 s_ack,
    output logic [7:0]           s_sel,
    output logic [FML_DW-1:0]    s_do,
    input  logic [FML_DW-1:0]    s_di
);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       owner_q, owner_d;
    logic       gnt1;
    logic       ackFire;
    logic       ackOwner;
    logic       dataEn;
    logic       dataSel1;

`ifndef FMLARB2_FIXED_PRIO_EN
    logic       last_q, last_d;
`endif

    fmlarb2_rr u_rr (
        .req0_i  (m0_stb),
        .req1_i  (m1_stb),
`ifndef FMLARB2_FIXED_PRIO_EN
        .last1_i (last_q),
`endif
        .gnt1_o  (gnt1)
    );

    // Read data needs no steering: both masters see the slave bus and the
    // owner's ack tells it when the data is valid.
    assign m0_di = s_di;
    assign m1_di = s_di;

    // Next-state and output logic.  The request stage holds the granted
    // master on the slave port until it is acked or withdraws.  The write
    // data mux opens in the ack cycle and stays open through DATA.  Reset
    // forces every output idle in the same cycle so an aborted burst cannot
    // leak one more ack or data beat.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        ackFire  = 1'b0;
        ackOwner = 1'b0;
        dataEn   = 1'b0;
        dataSel1 = owner_q;
        s_adr    = '0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_sel    = 8'h00;
        s_do     = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_stb || m1_stb) begin
                    state_d = gnt1 ? REQ1 : REQ0;
                end
            end

            REQ0: begin
                s_adr = m0_adr;
                s_we  = m0_we;
                s_stb = m0_stb;
                if (s_ack) begin
                    m0_ack   = 1'b1;
                    ackFire  = 1'b1;
                    ackOwner = 1'b0;
                    dataEn   = 1'b1;
                    dataSel1 = 1'b0;
                    owner_d  = 1'b0;
                    cnt_d    = DATA_CNT_INIT;
                    state_d  = DATA;
                end else if (!m0_stb) begin
                    state_d = IDLE;
                end
            end

            REQ1: begin
                s_adr = m1_adr;
                s_we  = m1_we;
                s_stb = m1_stb;
                if (s_ack) begin
                    m1_ack   = 1'b1;
                    ackFire  = 1'b1;
                    ackOwner = 1'b1;
                    dataEn   = 1'b1;
                    dataSel1 = 1'b1;
                    owner_d  = 1'b1;
                    cnt_d    = DATA_CNT_INIT;
                    state_d  = DATA;
                end else if (!m1_stb) begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                dataEn = 1'b1;
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (dataEn) begin
            s_do  = dataSel1 ? m1_do  : m0_do;
            s_sel = dataSel1 ? m1_sel : m0_sel;
        end

        if (sys_rst) begin
            s_adr  = '0;
            s_stb  = 1'b0;
            s_we   = 1'b0;
            s_sel  = 8'h00;
            s_do   = '0;
            m0_ack = 1'b0;
            m1_ack = 1'b0;
        end
    end

    // FSM, beat counter and data-owner registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

`ifndef FMLARB2_FIXED_PRIO_EN
    // Remember who was acked last so a tie goes to the other master.  Reset
    // value 1 means master 0 wins the first tie.
    always_comb begin
        last_d = ackFire ? ackOwner : last_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority keeps no history; the ack owner is only used above.
    logic unusedAckOwner;
    assign unusedAckOwner = ackFire & ackOwner;
`endif

endmodule
